// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_W      = 5;
   localparam int unsigned ADDR_SEL_W = 2;

   typedef enum logic [1:0] {
      NOHAZ = 2'b00,
      JUMP  = 2'b01,
      BR0   = 2'b10,
      BR1   = 2'b11
   } state_e;

   localparam logic [ADDR_SEL_W-1:0] ADDR_PC4    = 2'b00;
   localparam logic [ADDR_SEL_W-1:0] ADDR_JUMP   = 2'b01;
   localparam logic [ADDR_SEL_W-1:0] ADDR_BRANCH = 2'b10;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // One cycle's worth of pipeline control decided by the hazard unit.
   typedef struct packed {
      logic                  pc_write;
      logic                  if_write;
      logic                  bubble;
      logic [ADDR_SEL_W-1:0] addr_sel;
   } hazard_ctrl_t;

   function automatic hazard_ctrl_t mk_ctrl(input logic                  pc_write,
                                            input logic                  if_write,
                                            input logic                  bubble,
                                            input logic [ADDR_SEL_W-1:0] addr_sel);
      hazard_ctrl_t c;
      c.pc_write = pc_write;
      c.if_write = if_write;
      c.bubble   = bubble;
      c.addr_sel = addr_sel;
      return c;
   endfunction

endpackage

// File: rtl/hazard_if.sv
// ID/EX-side signal bundle between the pipeline and the hazard unit.
interface hazard_if;
   import hazard_pkg::*;

   logic [REG_W-1:0]      ID_Rs;
   logic [REG_W-1:0]      ID_Rt;
   logic                  UseRs;
   logic                  UseRt;
   logic [REG_W-1:0]      EX_Rw;
   logic                  EX_MemRead;
   logic                  Jump;
   logic                  Branch;
   logic                  ALUZero;
   logic                  PCWrite;
   logic                  IFWrite;
   logic                  Bubble;
   logic [ADDR_SEL_W-1:0] addrSel;

   // Pipeline side: supplies decode/EX fields, consumes control.
   modport master (
      output ID_Rs, ID_Rt, UseRs, UseRt, EX_Rw, EX_MemRead, Jump, Branch, ALUZero,
      input  PCWrite, IFWrite, Bubble, addrSel
   );

   // Hazard unit side.
   modport slave (
      input  ID_Rs, ID_Rt, UseRs, UseRt, EX_Rw, EX_MemRead, Jump, Branch, ALUZero,
      output PCWrite, IFWrite, Bubble, addrSel
   );
endinterface

// File: rtl/hazard_load_use_detect.sv
// Combinational load-use detector: a load in EX feeding a register read in EX next cycle.
module load_use_detect
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             use_rs,
   input  logic             use_rt,
   input  logic [REG_W-1:0] ex_rw,
   input  logic             ex_mem_read,
   output logic             lu_c
);

   logic rs_hit_c;
   logic rt_hit_c;

   // R0 is hardwired, so a load targeting it can never create a dependence.
   always_comb begin
      rs_hit_c = use_rs && (id_rs == ex_rw);
      rt_hit_c = use_rt && (id_rt == ex_rw);
      lu_c     = ex_mem_read && (ex_rw != REG_ZERO) && (rs_hit_c || rt_hit_c);
   end

endmodule

// File: rtl/hazard_unit.sv
// Mealy hazard FSM for the five-stage pipeline: stalls load-use, squashes after jumps and branches.
module hazard_unit
   import hazard_pkg::*;
(
   input  logic    CLK,
   input  logic    Reset_L,
   hazard_if.slave hz
);

   state_e       state_q;
   state_e       state_d;
   logic         lu_c;
   hazard_ctrl_t ctrl_c;

   load_use_detect u_load_use_detect (
      .id_rs       (hz.ID_Rs),
      .id_rt       (hz.ID_Rt),
      .use_rs      (hz.UseRs),
      .use_rt      (hz.UseRt),
      .ex_rw       (hz.EX_Rw),
      .ex_mem_read (hz.EX_MemRead),
      .lu_c        (lu_c)
   );

   // State register.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q <= NOHAZ;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; only NOHAZ and BR0 look at inputs, so X elsewhere cannot leak in.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         NOHAZ: begin
            if (lu_c) begin
               state_d = NOHAZ;
            end else if (hz.Jump) begin
               state_d = JUMP;
            end else if (hz.Branch) begin
               state_d = BR0;
            end else begin
               state_d = NOHAZ;
            end
         end
         JUMP:    state_d = NOHAZ;
         BR0:     state_d = hz.ALUZero ? BR1 : NOHAZ;
         BR1:     state_d = NOHAZ;
         default: state_d = NOHAZ;
      endcase
   end

   // Output decode; reset overrides everything so the pipeline free-runs from PC+4.
   always_comb begin
      ctrl_c = mk_ctrl(1'b1, 1'b1, 1'b0, ADDR_PC4);
      if (Reset_L) begin
         unique case (state_q)
            NOHAZ: begin
               if (lu_c) begin
                  ctrl_c = mk_ctrl(1'b0, 1'b0, 1'b1, ADDR_PC4);
               end else if (hz.Jump) begin
                  ctrl_c = mk_ctrl(1'b1, 1'b0, 1'b0, ADDR_JUMP);
               end else if (hz.Branch) begin
                  ctrl_c = mk_ctrl(1'b0, 1'b0, 1'b0, ADDR_PC4);
               end else begin
                  ctrl_c = mk_ctrl(1'b1, 1'b1, 1'b0, ADDR_PC4);
               end
            end
            JUMP: ctrl_c = mk_ctrl(1'b1, 1'b1, 1'b1, ADDR_PC4);
            BR0: begin
               if (hz.ALUZero) begin
                  ctrl_c = mk_ctrl(1'b1, 1'b0, 1'b1, ADDR_BRANCH);
               end else begin
                  ctrl_c = mk_ctrl(1'b1, 1'b1, 1'b1, ADDR_PC4);
               end
            end
            BR1:     ctrl_c = mk_ctrl(1'b1, 1'b1, 1'b1, ADDR_PC4);
            default: ctrl_c = mk_ctrl(1'b1, 1'b1, 1'b0, ADDR_PC4);
         endcase
      end
   end

   assign hz.PCWrite = ctrl_c.pc_write;
   assign hz.IFWrite = ctrl_c.if_write;
   assign hz.Bubble  = ctrl_c.bubble;
   assign hz.addrSel = ctrl_c.addr_sel;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: stimulus queues expected controls, a monitor checks them.
module tb_hazard_unit;

   logic clk;
   logic rst_n;

   hazard_if hz ();

   hazard_unit dut (
      .CLK     (clk),
      .Reset_L (rst_n),
      .hz      (hz)
   );

   typedef struct {
      logic [4:0] exp;   // {PCWrite, IFWrite, Bubble, addrSel[1:0]}
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t       e;
         logic [4:0] act;
         e   = exp_q.pop_front();
         act = {hz.PCWrite, hz.IFWrite, hz.Bubble, hz.addrSel};
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (PC,IF,Bub,Sel)", e.name, act, e.exp);
         end
      end
   end

   // One cycle of stimulus, applied shortly after the rising edge.
   task automatic cyc(input logic rstn, input logic mr, input logic [4:0] rw,
                      input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic j, input logic b, input logic az,
                      input logic [4:0] exp, input string nm);
      exp_t e;
      @(posedge clk);
      #2;
      rst_n         = rstn;
      hz.EX_MemRead = mr;
      hz.EX_Rw      = rw;
      hz.ID_Rs      = rs;
      hz.UseRs      = urs;
      hz.ID_Rt      = rt;
      hz.UseRt      = urt;
      hz.Jump       = j;
      hz.Branch     = b;
      hz.ALUZero    = az;
      e.exp  = exp;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic [4:0] exp, input string nm);
      cyc(1'b1, 1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, exp, nm);
   endtask

   initial begin
      rst_n         = 1'b0;
      hz.EX_MemRead = 1'b0;
      hz.EX_Rw      = 5'd0;
      hz.ID_Rs      = 5'd0;
      hz.UseRs      = 1'b0;
      hz.ID_Rt      = 5'd0;
      hz.UseRt      = 1'b0;
      hz.Jump       = 1'b1;
      hz.Branch     = 1'b0;
      hz.ALUZero    = 1'b0;

      // Reset held with Jump=1 and a live load-use pattern: outputs forced.
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11000, "rst_hold_jump");
      cyc(1'b0, 1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11000, "rst_hold_lu");
      // Release with Jump still high: first cycle takes the jump from NOHAZ.
      cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10001, "rel_jump_c0");
      idle(5'b11100, "rel_jump_c1");
      idle(5'b11000, "rel_jump_c2");

      // Load-use on Rs, then the load has moved on.
      cyc(1'b1, 1'b1, 5'd8, 5'd8, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100, "lu_rs_stall");
      cyc(1'b1, 1'b0, 5'd8, 5'd8, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, "lu_rs_after");
      // Load into R0 never stalls.
      cyc(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, "lu_r0_nostall");
      // Load-use on Rt, and the same match with UseRt low (store) does not stall.
      cyc(1'b1, 1'b1, 5'd9, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100, "lu_rt_stall");
      cyc(1'b1, 1'b1, 5'd9, 5'd4, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, "lu_rt_store");
      // Rs matches but not used: no stall.
      cyc(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, "lu_rs_unused");

      // Jump sequence.
      cyc(1'b1, 1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10001, "jump_c0");
      cyc(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'b11100, "jump_c1_ignores");
      idle(5'b11000, "jump_c2");

      // Branch taken; inputs in BR0/BR1 other than ALUZero are ignored.
      cyc(1'b1, 1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, "brt_c0");
      cyc(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 5'b10110, "brt_br0");
      cyc(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'b11100, "brt_br1");
      idle(5'b11000, "brt_done");

      // Branch not taken.
      cyc(1'b1, 1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, "brn_c0");
      cyc(1'b1, 1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11100, "brn_br0");
      idle(5'b11000, "brn_done");

      // Priority: load-use beats branch, then branch proceeds.
      cyc(1'b1, 1'b1, 5'd6, 5'd6, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00100, "prio_lu_br");
      cyc(1'b1, 1'b0, 5'd6, 5'd6, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, "prio_br_go");
      cyc(1'b1, 1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11100, "prio_br0_nt");
      // Priority: load-use beats jump, then jump beats branch.
      cyc(1'b1, 1'b1, 5'd6, 5'd1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00100, "prio_lu_jump");
      cyc(1'b1, 1'b0, 5'd6, 5'd1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 5'b10001, "prio_jump_br");
      idle(5'b11100, "prio_jump_c1");

      // Reset asserted mid-cycle while in BR0, then released.
      cyc(1'b1, 1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, "mid_rst_br");
      cyc(1'b0, 1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11000, "mid_rst_async");
      cyc(1'b1, 1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, "mid_rst_nohaz");
      cyc(1'b1, 1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10001, "mid_rst_jump");

      // Let the monitor drain the queue, bounded.
      begin
         int waited = 0;
         while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
         end
         if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
